biquad_seq: RTL and testbench

BIQUAD_SEQ -- requirements
Module: biquad_seq

---
 rtl/biquad_seq.sv | 172 +++++++++++++++++
 tb/tb_biquad_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad_seq.sv
// biquad_seq: direct-form-II-transposed biquad.
//   y   = sat((b0*x)>>>FRAC + s1)
//   s1' = sat(((b1*x - a1*y)>>>FRAC) + s2)
//   s2' = sat((b2*x - a2*y)>>>FRAC)
// A single WIDTHxWIDTH signed multiplier is shared across the five products
// in sequence (P_B0, P_B1, P_A1, P_B2, P_A2). The result is then held in
// HOLD until the consumer accepts it.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    sample handshake; in_data = x[n]
//   out_valid/out_ready  result handshake; out_data = y[n], held until next HOLD
//   cfg_we/addr/wdata    coefficient shadow write (0=b0 1=b1 2=b2 3=a1 4=a2)
//   state_clr            zero s1/s2 (honoured only in IDLE)
//   busy                 FSM is not IDLE
module biquad_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_wdata,
  input  logic             state_clr,
  output logic             busy
);

  localparam int PW = 2 * WIDTH;
  localparam int AW = 2 * WIDTH + 2;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    P_B0,
    P_B1,
    P_A1,
    P_B2,
    P_A2,
    HOLD
  } state_t;

  state_t state, nxt;

  logic signed [WIDTH-1:0] shadow [5];
  logic signed [WIDTH-1:0] coef   [5];
  logic signed [WIDTH-1:0] x_q, y_q, s1, s2, out_q;
  logic signed [AW-1:0]    acc1, acc2;
  logic signed [WIDTH-1:0] mul_a, mul_b;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    prod_x;
  logic signed [WIDTH-1:0] y_new, s1_new, s2_new;
  logic                    accept;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [AW-1:0] v);
    if (v > SAT_MAX)
      sat = {1'b0, {(WIDTH-1){1'b1}}};
    else if (v < SAT_MIN)
      sat = {1'b1, {(WIDTH-1){1'b0}}};
    else
      sat = v[WIDTH-1:0];
  endfunction

  assign accept    = in_valid && (state == IDLE);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign out_data  = out_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= nxt;
  end

  // FSM next state
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = P_B0;
      P_B0:    nxt = P_B1;
      P_B1:    nxt = P_A1;
      P_A1:    nxt = P_B2;
      P_B2:    nxt = P_A2;
      P_A2:    nxt = HOLD;
      HOLD:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Shared multiplier operand selection
  always_comb begin
    mul_a = coef[0];
    mul_b = x_q;
    case (state)
      P_B1:    mul_a = coef[1];
      P_A1:    begin mul_a = coef[3]; mul_b = y_q; end
      P_B2:    mul_a = coef[2];
      P_A2:    begin mul_a = coef[4]; mul_b = y_q; end
      default: ;
    endcase
  end

  assign prod   = PW'(mul_a) * PW'(mul_b);
  assign prod_x = AW'(prod);

  assign y_new  = sat((prod_x >>> FRAC) + AW'(s1));
  assign s1_new = sat((acc1 >>> FRAC) + AW'(s2));
  assign s2_new = sat((acc2 - prod_x) >>> FRAC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 5; i++) begin
        shadow[i] <= '0;
        coef[i]   <= '0;
      end
      x_q   <= '0;
      y_q   <= '0;
      s1    <= '0;
      s2    <= '0;
      out_q <= '0;
      acc1  <= '0;
      acc2  <= '0;
    end else begin
      for (int unsigned i = 0; i < 5; i++) begin
        if (cfg_we && cfg_addr == 3'(i))
          shadow[i] <= cfg_wdata;
      end

      // Active bank loads on accept; a write in the same cycle bypasses the
      // shadow so the sample being accepted already sees it.
      if (accept) begin
        x_q <= in_data;
        for (int unsigned i = 0; i < 5; i++) begin
          if (cfg_we && cfg_addr == 3'(i))
            coef[i] <= cfg_wdata;
          else
            coef[i] <= shadow[i];
        end
      end

      if (state == IDLE && state_clr) begin
        s1 <= '0;
        s2 <= '0;
      end

      case (state)
        P_B0: y_q  <= y_new;
        P_B1: acc1 <= prod_x;
        P_A1: acc1 <= acc1 - prod_x;
        P_B2: acc2 <= prod_x;
        P_A2: begin
          s1    <= s1_new;
          s2    <= s2_new;
          out_q <= y_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_seq.sv
`timescale 1ns/1ps
// Randomized + directed bench for biquad_seq against a wide-integer
// arithmetic model of the biquad equations.
module tb_biquad_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic        state_clr = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  biquad_seq #(.WIDTH(32), .FRAC(14)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .state_clr (state_clr),
    .busy      (busy)
  );

  // Reference model state
  logic signed [31:0] m_sh  [5];
  logic signed [31:0] m_act [5];
  logic signed [31:0] m_s1, m_s2;

  localparam logic signed [127:0] MX = 128'sd2147483647;
  localparam logic signed [127:0] MN = -128'sd2147483648;

  function automatic logic signed [31:0] msat(input logic signed [127:0] v);
    if (v > MX) return 32'h7FFFFFFF;
    if (v < MN) return 32'h80000000;
    return v[31:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_sh[i]  = '0;
      m_act[i] = '0;
    end
    m_s1 = '0;
    m_s2 = '0;
  endtask

  task automatic model_sample(input logic signed [31:0] x, output logic [31:0] y);
    logic signed [127:0] xx, yy, ns1;
    logic signed [127:0] c [5];
    logic signed [31:0]  yv;
    xx = x;
    for (int i = 0; i < 5; i++) c[i] = m_act[i];
    yv   = msat(((c[0] * xx) >>> 14) + m_s1);
    yy   = yv;
    ns1  = msat(((c[1] * xx - c[3] * yy) >>> 14) + m_s2);
    m_s2 = msat((c[2] * xx - c[4] * yy) >>> 14);
    m_s1 = ns1[31:0];
    y    = yv;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    cyc();
    cfg_we = 1'b0;
    if (a < 3'd5) m_sh[a] = d;
  endtask

  task automatic do_sample(
    input  logic [31:0] x,
    input  bit          clr,
    input  bit          acc_wr, input logic [2:0] acc_a, input logic [31:0] acc_d,
    input  bit          mid_wr, input logic [2:0] mid_a, input logic [31:0] mid_d,
    input  bit          mid_clr,
    input  int          hold,
    output logic [31:0] y_obs,
    output time         t_a
  );
    logic [31:0] y_exp, held;
    int lat;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    in_valid = 1'b1; in_data = x; state_clr = clr;
    cfg_we = acc_wr; cfg_addr = acc_a; cfg_wdata = acc_d;
    @(posedge clk);
    t_a = $time;
    #1;
    in_valid = 1'b0; state_clr = 1'b0; cfg_we = 1'b0;
    if (acc_wr && acc_a < 3'd5) m_sh[acc_a] = acc_d;
    for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
    if (clr) begin m_s1 = '0; m_s2 = '0; end
    model_sample(x, y_exp);
    check("busy", 32'(busy), 32'd1);
    // lat counts rising edges with the accepting edge as 1
    lat = 1;
    while (!out_valid && lat < 20) begin
      if (lat == 2 && (mid_wr || mid_clr)) begin
        cfg_we = mid_wr; cfg_addr = mid_a; cfg_wdata = mid_d; state_clr = mid_clr;
        if (mid_wr && mid_a < 3'd5) m_sh[mid_a] = mid_d;
      end else begin
        cfg_we = 1'b0; state_clr = 1'b0;
      end
      cyc();
      lat++;
    end
    cfg_we = 1'b0; state_clr = 1'b0;
    check("latency", 32'(lat), 32'd6);
    check("y", out_data, y_exp);
    check("in_ready_hold", 32'(in_ready), 32'd0);
    y_obs = out_data;
    held  = out_data;
    for (int h = 0; h < hold; h++) begin
      cyc();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", out_data, held);
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    cyc();
    check("release_valid", 32'(out_valid), 32'd0);
    check("data_kept", out_data, held);
  endtask

  task automatic samp(input logic [31:0] x, input bit clr, output logic [31:0] y);
    time t;
    do_sample(x, clr, 1'b0, 3'd0, '0, 1'b0, 3'd0, '0, 1'b0, 0, y, t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] y;
    time t, tprev;
    int prev_hold, hold;
    bit clr, aw, mw;
    logic [2:0] aa, ma;
    logic [31:0] ad, md, x;

    model_reset();
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    #10 rst_n = 1'b1;

    // Pass-through
    cfg_write(3'd0, 32'd16384);
    samp(32'd1000, 1'b0, y); check("pass", y, 32'd1000);

    // FIR tap
    cfg_write(3'd1, 32'd8192);
    samp(32'd1000, 1'b0, y); check("fir0", y, 32'd1000);
    samp(32'd0, 1'b0, y);    check("fir1", y, 32'd500);
    cfg_write(3'd1, 32'd0);
    cfg_write(3'd0, 32'd8192);
    samp(32'hFFFFFFFD, 1'b1, y); check("floor_neg", y, 32'hFFFFFFFE);

    // Feedback and IDLE clear
    cfg_write(3'd0, 32'd16384);
    cfg_write(3'd3, 32'hFFFFE000);
    samp(32'd1000, 1'b1, y); check("fb0", y, 32'd1000);
    samp(32'd0, 1'b0, y);    check("fb1", y, 32'd500);
    samp(32'd0, 1'b0, y);    check("fb2", y, 32'd250);
    state_clr = 1'b1; cyc(); state_clr = 1'b0;
    m_s1 = '0; m_s2 = '0;
    samp(32'd0, 1'b0, y);    check("fb_clr", y, 32'd0);

    // Saturation
    cfg_write(3'd3, 32'd0);
    cfg_write(3'd0, 32'd32768);
    samp(32'h7FFFFFFF, 1'b1, y); check("sat_pos", y, 32'h7FFFFFFF);
    samp(32'h80000000, 1'b0, y); check("sat_neg", y, 32'h80000000);

    // Backpressure with a b0 write while busy
    cfg_write(3'd0, 32'd16384);
    do_sample(32'd1234, 1'b1, 1'b0, 3'd0, '0, 1'b1, 3'd0, 32'd8192, 1'b0, 10, y, t);
    check("mid_wr_cur", y, 32'd1234);
    samp(32'd1234, 1'b0, y); check("mid_wr_next", y, 32'd617);

    // Same-cycle write visible to accepted sample
    do_sample(32'd500, 1'b1, 1'b1, 3'd0, 32'd16384, 1'b0, 3'd0, '0, 1'b0, 0, y, t);
    check("same_cycle_wr", y, 32'd500);

    // state_clr while busy is ignored
    cfg_write(3'd3, 32'hFFFFE000);
    do_sample(32'd1000, 1'b1, 1'b0, 3'd0, '0, 1'b0, 3'd0, '0, 1'b1, 0, y, t);
    check("busy_clr0", y, 32'd1000);
    samp(32'd0, 1'b0, y); check("busy_clr1", y, 32'd500);

    // Reset in P_A1 with nonzero filter state
    samp(32'd1000, 1'b1, y);
    in_valid = 1'b1; in_data = 32'd777;
    cyc();
    in_valid = 1'b0;
    cyc(); cyc();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    do_sample(32'd1234, 1'b0, 1'b1, 3'd0, 32'd16384, 1'b0, 3'd0, '0, 1'b0, 0, y, t);
    check("post_rst", y, 32'd1234);

    // Randomized run, back-to-back, with throughput tracking
    for (int i = 0; i < 5; i++)
      cfg_write(3'(i), 32'($urandom_range(0, 65535)) - 32'd32768);
    prev_hold = 0;
    tprev = 0;
    for (int i = 0; i < 40; i++) begin
      x    = (i % 8 == 7) ? 32'h7FFFFFFF : $urandom;
      clr  = ($urandom_range(0, 3) == 0);
      aw   = ($urandom_range(0, 3) == 0);
      aa   = 3'($urandom_range(0, 7));
      ad   = 32'($urandom_range(0, 65535)) - 32'd32768;
      mw   = ($urandom_range(0, 2) == 0);
      ma   = 3'($urandom_range(0, 7));
      md   = 32'($urandom_range(0, 65535)) - 32'd32768;
      hold = $urandom_range(0, 3);
      do_sample(x, clr, aw, aa, ad, mw, ma, md, ($urandom_range(0, 4) == 0), hold, y, t);
      if (i > 0) check("throughput", 32'((t - tprev) / 10), 32'(7 + prev_hold));
      tprev = t;
      prev_hold = hold;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
